// File: rtl/log_compress.sv
// ---------------------------------------------------------------------------
// log_compress -- three-stage logarithmic compressor for normalized samples.
//
// Converts a normalized mantissa plus its normalization shift into a Q4.8
// log2 value (Mitchell approximation, optionally refined by a 16-entry
// correction LUT), then maps the log value above a dynamic-range floor onto
// an OUT_WIDTH display sample with a fixed gain and a clamp at full scale.
//
// Pipeline: S1 decode (exponent/fraction) -> S2 log (+correction, saturate)
//           -> S3 scale/clamp into the output register.
// Flow control: one global stall (out_valid && !out_ready) freezes all
// stages, so in_ready = !stall and throughput is one sample per cycle.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high reset
//   in_valid   in   upstream sample valid
//   in_ready   out  sample accepted this cycle when in_valid is high
//   data_in    in   normalized mantissa (MSB set for a real sample)
//   shift_in   in   left-shift applied by the normalizer
//   out_valid  out  data_out valid
//   out_ready  in   downstream accepts data_out
//   data_out   out  log-compressed sample
//   clip_count out  saturating count of delivered samples clamped to max
//
// Build option: define LOG_COMPRESS_CORR_EN to compile in the log2
// correction LUT; otherwise the correction term is zero.
// ---------------------------------------------------------------------------
module log_compress #(
   parameter int          DATA_WIDTH = 16,
   parameter int          OUT_WIDTH  = 8,
   parameter logic [11:0] LOG_FLOOR  = 12'd0,
   parameter logic [7:0]  GAIN       = 8'd17
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_WIDTH-1:0]         data_in,
   input  logic [$clog2(DATA_WIDTH)-1:0] shift_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [OUT_WIDTH-1:0]          data_out,
   output logic [15:0]                   clip_count
);

   localparam int unsigned OUT_MAX = (2 ** OUT_WIDTH) - 1;

   // Stage registers
   logic        s1_valid_r;
   logic        s1_msb_r;
   logic [3:0]  s1_exp_r;
   logic [7:0]  s1_frac_r;
   logic        s2_valid_r;
   logic        s2_msb_r;
   logic [11:0] s2_log_r;
   logic        out_clip_r;

   // Combinational intermediates
   logic        stall_s;
   logic [3:0]  exp_s;
   logic [7:0]  frac_s;
   logic [7:0]  corr_s;
   logic [12:0] sum_s;
   logic [11:0] log_s;
   logic        above_s;
   logic [11:0] diff_s;
   logic [19:0] prod_s;
   logic [31:0] scaled_s;
   logic        clip_s;
   logic [OUT_WIDTH-1:0] result_s;
   logic        unused_bits_s;

   // Mantissa bits below the 8-bit fraction and the product's fractional
   // byte do not contribute to the result.
   assign unused_bits_s = ^{data_in[DATA_WIDTH-10:0], prod_s[7:0]};

`ifdef LOG_COMPRESS_CORR_EN
   // round(256*(log2(1+k/16) - k/16)): error of the linear Mitchell
   // approximation sampled at the top four fraction bits.
   function automatic logic [7:0] corr_lut(input logic [3:0] k);
      case (k)
         4'd0:    corr_lut = 8'd0;
         4'd1:    corr_lut = 8'd6;
         4'd2:    corr_lut = 8'd12;
         4'd3:    corr_lut = 8'd15;
         4'd4:    corr_lut = 8'd18;
         4'd5:    corr_lut = 8'd20;
         4'd6:    corr_lut = 8'd22;
         4'd7:    corr_lut = 8'd22;
         4'd8:    corr_lut = 8'd22;
         4'd9:    corr_lut = 8'd21;
         4'd10:   corr_lut = 8'd19;
         4'd11:   corr_lut = 8'd17;
         4'd12:   corr_lut = 8'd15;
         4'd13:   corr_lut = 8'd12;
         4'd14:   corr_lut = 8'd8;
         4'd15:   corr_lut = 8'd4;
         default: corr_lut = 8'd0;
      endcase
   endfunction

   // Correction term from the LUT
   always_comb begin
      corr_s = corr_lut(s1_frac_r[7:4]);
   end
`else
   // Pure Mitchell approximation: no correction
   always_comb begin
      corr_s = 8'd0;
   end
`endif

   // Global stall: the output register is occupied and not being taken
   always_comb begin
      stall_s  = out_valid && !out_ready;
      in_ready = !stall_s;
   end

   // S1 decode: integer log2 from the shift, fraction from the bits under the MSB
   always_comb begin
      exp_s  = 4'((DATA_WIDTH - 1) - int'(shift_in));
      frac_s = data_in[DATA_WIDTH-2 -: 8];
   end

   // S1 register
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_r <= 1'b0;
         s1_msb_r   <= 1'b0;
         s1_exp_r   <= 4'd0;
         s1_frac_r  <= 8'd0;
      end else if (!stall_s) begin
         s1_valid_r <= in_valid;
         s1_msb_r   <= data_in[DATA_WIDTH-1];
         s1_exp_r   <= exp_s;
         s1_frac_r  <= frac_s;
      end else begin
         s1_valid_r <= s1_valid_r;
      end
   end

   // S2 log: Q4.8 value plus correction, saturating at the top of the range
   always_comb begin
      sum_s = {1'b0, s1_exp_r, s1_frac_r} + {5'd0, corr_s};
      if (sum_s[12]) begin
         log_s = 12'hFFF;
      end else begin
         log_s = sum_s[11:0];
      end
   end

   // S2 register
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid_r <= 1'b0;
         s2_msb_r   <= 1'b0;
         s2_log_r   <= 12'd0;
      end else if (!stall_s) begin
         s2_valid_r <= s1_valid_r;
         s2_msb_r   <= s1_msb_r;
         s2_log_r   <= log_s;
      end else begin
         s2_valid_r <= s2_valid_r;
      end
   end

   // S3 scale/clamp: gain applied to the distance above the floor; a sample
   // whose MSB was clear is not a real measurement and yields zero.
   always_comb begin
      above_s  = s2_log_r > LOG_FLOOR;
      diff_s   = s2_log_r - LOG_FLOOR;
      prod_s   = {8'd0, diff_s} * {12'd0, GAIN};
      scaled_s = {20'd0, prod_s[19:8]};
      clip_s   = 1'b0;
      result_s = '0;
      if (s2_msb_r && above_s) begin
         if (scaled_s >= OUT_MAX) begin
            clip_s   = 1'b1;
            result_s = OUT_WIDTH'(OUT_MAX);
         end else begin
            result_s = scaled_s[OUT_WIDTH-1:0];
         end
      end else begin
         result_s = '0;
      end
   end

   // S3 / output register, frozen while stalled
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid  <= 1'b0;
         data_out   <= '0;
         out_clip_r <= 1'b0;
      end else if (!stall_s) begin
         out_valid  <= s2_valid_r;
         data_out   <= result_s;
         out_clip_r <= clip_s && s2_valid_r;
      end else begin
         out_valid  <= out_valid;
      end
   end

   // Clip counter: counts clamped samples as they are delivered, saturating
   always_ff @(posedge clk) begin
      if (reset) begin
         clip_count <= 16'd0;
      end else if (out_valid && out_ready && out_clip_r && (clip_count != 16'hFFFF)) begin
         clip_count <= clip_count + 16'd1;
      end else begin
         clip_count <= clip_count;
      end
   end

endmodule

// File: tb/tb_log_compress.sv
// ---------------------------------------------------------------------------
// tb_log_compress -- self-checking bench for log_compress.
// Expected samples come from a real-arithmetic log2 model; a queue of
// expectations is pushed on every input handshake and popped on every
// output handshake, so order, loss and duplication are all observed.
// ---------------------------------------------------------------------------
module tb_log_compress;

   localparam int          DW    = 16;
   localparam int          OW    = 8;
   localparam logic [11:0] FLOOR = 12'd0;
   localparam logic [7:0]  GAIN  = 8'd17;

`ifdef LOG_COMPRESS_CORR_EN
   localparam bit CORR_EN = 1'b1;
`else
   localparam bit CORR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] data_in;
   logic [3:0]    shift_in;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] data_out;
   logic [15:0]   clip_count;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int out_n  = 0;
   int exp_clip = 0;
   int last_out = 0;
   bit lat_chk  = 1'b0;
   bit stalled_prev = 1'b0;
   logic [OW-1:0] prev_data;

   int exp_q[$];
   bit clip_q[$];
   int acc_q[$];

   log_compress #(
      .DATA_WIDTH(DW),
      .OUT_WIDTH (OW),
      .LOG_FLOOR (FLOOR),
      .GAIN      (GAIN)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .shift_in  (shift_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .clip_count(clip_count)
   );

   always #5 clk = ~clk;

   // Correction computed directly from its definition
   function automatic int corr(input int k);
      real x;
      x = real'(k) / 16.0;
      if (CORR_EN) return $rtoi($floor(256.0 * ($ln(1.0 + x) / $ln(2.0) - x) + 0.5));
      else return 0;
   endfunction

   // Reference: log2 of the sample in Q4.8, then floor/gain/clamp
   function automatic void ref_model(input logic [DW-1:0] d, input int sh,
                                     output int v, output bit clip);
      int e, f, l;
      e = (DW - 1) - sh;
      f = int'(d[DW-2 -: 8]);
      l = e * 256 + f + corr(f / 16);
      if (l > 4095) l = 4095;
      v = 0;
      clip = 1'b0;
      if (d[DW-1] && l > int'(FLOOR)) begin
         v = ((l - int'(FLOOR)) * int'(GAIN)) / 256;
         if (v >= 255) begin
            v = 255;
            clip = 1'b1;
         end
      end
   endfunction

   // One clock: sample at negedge, score handshakes, return 1 after posedge
   task automatic cycle();
      int v, a;
      bit c;
      @(negedge clk);
      if (stalled_prev) begin
         checks++;
         if (data_out !== prev_data)
            begin errors++; $display("FAIL hold_stable: data_out=%0d required=%0d", data_out, prev_data); end
      end
      checks++;
      if (in_ready !== !(out_valid && !out_ready))
         begin errors++; $display("FAIL in_ready_rule: in_ready=%b out_valid=%b out_ready=%b", in_ready, out_valid, out_ready); end
      if (out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++; $display("FAIL unexpected_output: data_out=%0d required=none", data_out);
         end else begin
            v = exp_q.pop_front();
            c = clip_q.pop_front();
            a = acc_q.pop_front();
            if (data_out !== OW'(v))
               begin errors++; $display("FAIL data_out: got=%0d required=%0d", data_out, v); end
            if (c && exp_clip < 65535) exp_clip++;
            if (lat_chk) begin
               checks++;
               if (cyc - a != 3)
                  begin errors++; $display("FAIL latency: got=%0d required=3", cyc - a); end
            end
            last_out = int'(data_out);
            out_n++;
         end
      end
      if (in_valid && in_ready) begin
         ref_model(data_in, int'(shift_in), v, c);
         exp_q.push_back(v);
         clip_q.push_back(c);
         acc_q.push_back(cyc);
      end
      stalled_prev = out_valid && !out_ready && !reset;
      prev_data = data_out;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 60 && exp_q.size() > 0; i++) cycle();
      checks++;
      if (exp_q.size() != 0)
         begin errors++; $display("FAIL drain_timeout: pending=%0d required=0", exp_q.size()); end
      exp_q.delete(); clip_q.delete(); acc_q.delete();
   endtask

   task automatic check_clip(input string name);
      checks++;
      if (clip_count !== 16'(exp_clip))
         begin errors++; $display("FAIL %s: clip_count=%0d required=%0d", name, clip_count, exp_clip); end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      data_in = 16'h0000; shift_in = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got=%b required=0", out_valid); end
      checks++; if (data_out !== 8'd0) begin errors++; $display("FAIL rst_data_out: got=%0d required=0", data_out); end
      checks++; if (clip_count !== 16'd0) begin errors++; $display("FAIL rst_clip: got=%0d required=0", clip_count); end
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got=%b required=1", in_ready); end
   endtask

   task automatic test_directed();
      logic [15:0] d_tab[6];
      logic [3:0]  s_tab[6];
      int          e_tab[6];
      d_tab = '{16'h8000, 16'h8000, 16'hC000, 16'h4000, 16'h8000, 16'h8000};
      s_tab = '{4'd15,    4'd7,     4'd4,     4'd3,     4'd0,     4'd0};
      e_tab = '{0, 136, CORR_EN ? 196 : 195, 0, 255, 255};
      lat_chk = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; data_in = d_tab[i]; shift_in = s_tab[i];
         cycle();
         drain();
         checks++;
         if (last_out != e_tab[i])
            begin errors++; $display("FAIL directed_%0d: data_out=%0d required=%0d", i, last_out, e_tab[i]); end
         if (i == 4) begin
            checks++;
            if (clip_count !== 16'd1) begin errors++; $display("FAIL clip_first: got=%0d required=1", clip_count); end
         end
      end
      checks++;
      if (clip_count !== 16'd2) begin errors++; $display("FAIL clip_second: got=%0d required=2", clip_count); end
      lat_chk = 1'b0;
   endtask

   task automatic test_random();
      logic [15:0] d;
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         d = 16'($urandom);
         d[15] = ($urandom_range(0, 7) != 0);
         data_in = d;
         shift_in = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      drain();
      check_clip("clip_random");
   endtask

   task automatic test_back_to_back();
      logic [15:0] d_tab[8];
      logic [3:0]  s_tab[8];
      int n0, in_n;
      for (int i = 0; i < 8; i++) begin
         d_tab[i] = 16'($urandom) | 16'h8000;
         s_tab[i] = 4'($urandom_range(0, 15));
      end
      n0 = out_n;
      in_n = 0;
      for (int c = 0; c < 40 && (in_n < 8 || exp_q.size() > 0); c++) begin
         in_valid  = (in_n < 8);
         data_in   = d_tab[in_n < 8 ? in_n : 7];
         shift_in  = s_tab[in_n < 8 ? in_n : 7];
         out_ready = !(c >= 4 && c <= 8);
         #1;
         if (c >= 4 && c <= 8) begin
            checks++;
            if (in_ready !== 1'b0)
               begin errors++; $display("FAIL b2b_in_ready: cycle=%0d got=%b required=0", c, in_ready); end
         end
         if (in_valid && in_ready) in_n++;
         cycle();
      end
      drain();
      checks++;
      if (out_n - n0 != 8)
         begin errors++; $display("FAIL b2b_count: got=%0d required=8", out_n - n0); end
      check_clip("clip_b2b");
   endtask

   task automatic test_reset_midflight();
      int n0;
      out_ready = 1'b1;
      in_valid = 1'b1; data_in = 16'h8000; shift_in = 4'd0;
      repeat (3) cycle();
      in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1;
      cycle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got=%b required=0", out_valid); end
      checks++; if (clip_count !== 16'd0) begin errors++; $display("FAIL mid_rst_clip: got=%0d required=0", clip_count); end
      reset = 1'b0;
      exp_q.delete(); clip_q.delete(); acc_q.delete();
      exp_clip = 0;
      n0 = out_n;
      out_ready = 1'b1;
      repeat (10) cycle();
      checks++;
      if (out_n != n0) begin errors++; $display("FAIL stale_output: got=%0d required=0", out_n - n0); end
      check_clip("clip_after_rst");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
